// File: rtl/wb_arbiter_2m_if.sv
// rtl/wb_arbiter_2m_if.sv - bus bundle for the two-master Wishbone arbiter
interface wb_arbiter_2m_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   m0_adr_i;
    logic [DW-1:0]   m0_dat_i;
    logic [DW-1:0]   m0_dat_o;
    logic            m0_we_i;
    logic [DW/8-1:0] m0_sel_i;
    logic            m0_stb_i;
    logic            m0_cyc_i;
    logic            m0_ack_o;
    logic            m0_err_o;

    logic [AW-1:0]   m1_adr_i;
    logic [DW-1:0]   m1_dat_i;
    logic [DW-1:0]   m1_dat_o;
    logic            m1_we_i;
    logic [DW/8-1:0] m1_sel_i;
    logic            m1_stb_i;
    logic            m1_cyc_i;
    logic            m1_ack_o;
    logic            m1_err_o;

    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_we_o;
    logic [DW/8-1:0] s_sel_o;
    logic            s_stb_o;
    logic            s_cyc_o;
    logic            s_ack_i;

    logic            grant_o;

    // Arbiter side: it is the slave of both masters and drives the shared slave port.
    modport slave (
        input  m0_adr_i, m0_dat_i, m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_adr_i, m1_dat_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
        input  s_dat_i, s_ack_i,
        output grant_o
    );

    modport master (
        output m0_adr_i, m0_dat_i, m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_adr_i, m1_dat_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
        output s_dat_i, s_ack_i,
        input  grant_o
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master Wishbone classic arbiter, round-robin per bus cycle with timeout watchdog
module wb_arbiter_2m #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_arbiter_2m_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, ERR, WREL} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;
    logic [DW/8-1:0] g_sel;
    logic            g_we, g_stb, g_cyc;
    logic            ack_g, err_g;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        g_adr = grant_q ? bus.m1_adr_i : bus.m0_adr_i;
        g_dat = grant_q ? bus.m1_dat_i : bus.m0_dat_i;
        g_sel = grant_q ? bus.m1_sel_i : bus.m0_sel_i;
        g_we  = grant_q ? bus.m1_we_i  : bus.m0_we_i;
        g_stb = grant_q ? bus.m1_stb_i : bus.m0_stb_i;
        g_cyc = grant_q ? bus.m1_cyc_i : bus.m0_cyc_i;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_we_o  = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_cyc_o = 1'b0;
        ack_g       = 1'b0;
        err_g       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.m0_cyc_i || bus.m1_cyc_i) begin
                    grant_d = (bus.m0_cyc_i && bus.m1_cyc_i) ? ~last_q : bus.m1_cyc_i;
                    last_d  = grant_d;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.s_adr_o = g_adr;
                bus.s_dat_o = g_dat;
                bus.s_sel_o = g_sel;
                bus.s_we_o  = g_we;
                bus.s_cyc_o = g_cyc;
                bus.s_stb_o = g_cyc & g_stb;
                ack_g       = bus.s_ack_i & g_stb;
                // A stalled strobe counts up; an ack on the deciding edge still wins.
                if (bus.s_stb_o && !bus.s_ack_i) begin
                    if (cnt_q != CNT_MAX)
                        cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                end
                if (!g_cyc)
                    state_d = IDLE;
                else if (TIMEOUT_CYCLES != 0 && bus.s_stb_o && !bus.s_ack_i && cnt_q == CNT_LAST)
                    state_d = ERR;
            end
            ERR: begin
                err_g   = 1'b1;
                cnt_d   = '0;
                state_d = WREL;
            end
            WREL: begin
                if (!g_cyc)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m0_ack_o = ack_g & ~grant_q;
    assign bus.m1_ack_o = ack_g &  grant_q;
    assign bus.m0_err_o = err_g & ~grant_q;
    assign bus.m1_err_o = err_g &  grant_q;
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;
    assign bus.grant_o  = grant_q;
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - directed self-checking bench for wb_arbiter_2m
module tb_wb_arbiter_2m;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_err;

    always #5 clk = ~clk;

    wb_arbiter_2m_if #(.AW(32), .DW(32)) bus_a ();
    wb_arbiter_2m_if #(.AW(32), .DW(32)) bus_b ();

    wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut_a (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus_a.slave)
    );

    wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT_CYCLES(0)) dut_b (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus_b.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus_a.m0_adr_i = '0; bus_a.m0_dat_i = '0; bus_a.m0_we_i = 0; bus_a.m0_sel_i = '0;
        bus_a.m0_stb_i = 0;  bus_a.m0_cyc_i = 0;
        bus_a.m1_adr_i = '0; bus_a.m1_dat_i = '0; bus_a.m1_we_i = 0; bus_a.m1_sel_i = '0;
        bus_a.m1_stb_i = 0;  bus_a.m1_cyc_i = 0;
        bus_a.s_dat_i  = '0; bus_a.s_ack_i  = 0;
        bus_b.m0_adr_i = '0; bus_b.m0_dat_i = '0; bus_b.m0_we_i = 0; bus_b.m0_sel_i = '0;
        bus_b.m0_stb_i = 0;  bus_b.m0_cyc_i = 0;
        bus_b.m1_adr_i = '0; bus_b.m1_dat_i = '0; bus_b.m1_we_i = 0; bus_b.m1_sel_i = '0;
        bus_b.m1_stb_i = 0;  bus_b.m1_cyc_i = 0;
        bus_b.s_dat_i  = '0; bus_b.s_ack_i  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset state
        clear_inputs();
        @(negedge clk);
        check_eq("rst_grant", bus_a.grant_o, 0);
        check_eq("rst_s_cyc", bus_a.s_cyc_o, 0);
        check_eq("rst_s_stb", bus_a.s_stb_o, 0);
        check_eq("rst_s_we",  bus_a.s_we_o, 0);
        check_eq("rst_acks",  {bus_a.m0_ack_o, bus_a.m1_ack_o, bus_a.m0_err_o, bus_a.m1_err_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single master read
        step();
        bus_a.m0_cyc_i = 1; bus_a.m0_stb_i = 1; bus_a.m0_adr_i = 32'h1000; bus_a.m0_sel_i = 4'hf;
        mid();
        check_eq("t1_idle_lat", bus_a.s_cyc_o, 0);
        step();
        mid();
        check_eq("t1_s_cyc", bus_a.s_cyc_o, 1);
        check_eq("t1_s_adr", bus_a.s_adr_o, 32'h1000);
        check_eq("t1_no_ack_yet", bus_a.m0_ack_o, 0);
        step();
        step();
        bus_a.s_ack_i = 1; bus_a.s_dat_i = 32'hDEADBEEF;
        mid();
        check_eq("t1_m0_ack", bus_a.m0_ack_o, 1);
        check_eq("t1_m0_dat", bus_a.m0_dat_o, 32'hDEADBEEF);
        check_eq("t1_m1_ack", bus_a.m1_ack_o, 0);
        step();
        bus_a.s_ack_i = 0; bus_a.m0_cyc_i = 0; bus_a.m0_stb_i = 0;
        step();
        mid();
        check_eq("t1_release", bus_a.s_cyc_o, 0);

        // Simultaneous requests, dead cycle, round robin
        do_reset();
        step();
        bus_a.m0_cyc_i = 1; bus_a.m0_stb_i = 1; bus_a.m1_cyc_i = 1; bus_a.m1_stb_i = 1;
        step();
        mid();
        check_eq("t2_first_m0", bus_a.grant_o, 0);
        check_eq("t2_first_cyc", bus_a.s_cyc_o, 1);
        step();
        bus_a.m0_cyc_i = 0; bus_a.m0_stb_i = 0;
        step();
        mid();
        check_eq("t2_dead_cyc", bus_a.s_cyc_o, 0);
        step();
        mid();
        check_eq("t2_then_m1", bus_a.grant_o, 1);
        check_eq("t2_m1_cyc", bus_a.s_cyc_o, 1);
        step();
        bus_a.m1_cyc_i = 0; bus_a.m1_stb_i = 0; bus_a.m0_cyc_i = 1; bus_a.m0_stb_i = 1;
        step();
        bus_a.m1_cyc_i = 1; bus_a.m1_stb_i = 1;
        step();
        mid();
        check_eq("t2_rr_m0", bus_a.grant_o, 0);
        step();
        bus_a.m0_cyc_i = 0; bus_a.m0_stb_i = 0;
        step();
        step();
        mid();
        check_eq("t2_rr_m1", bus_a.grant_o, 1);

        // m1 holds the bus across three strobe phases while m0 waits
        do_reset();
        step();
        bus_a.m1_cyc_i = 1; bus_a.m1_stb_i = 1; bus_a.m1_we_i = 1;
        bus_a.m1_dat_i = 32'h55; bus_a.m1_sel_i = 4'b0001; bus_a.m1_adr_i = 32'h2000;
        step();
        bus_a.m0_cyc_i = 1; bus_a.m0_stb_i = 1; bus_a.m0_adr_i = 32'h3000; bus_a.s_ack_i = 1;
        mid();
        check_eq("t3_grant_m1", bus_a.grant_o, 1);
        check_eq("t3_wr_we", bus_a.s_we_o, 1);
        check_eq("t3_wr_sel", bus_a.s_sel_o, 4'b0001);
        check_eq("t3_wr_dat", bus_a.s_dat_o, 32'h55);
        check_eq("t3_wr_ack", {bus_a.m1_ack_o, bus_a.m0_ack_o}, 2'b10);
        step();
        bus_a.m1_we_i = 0; bus_a.m1_sel_i = 4'hf; bus_a.m1_adr_i = 32'h2004;
        mid();
        check_eq("t3_rd1_we", bus_a.s_we_o, 0);
        check_eq("t3_rd1_sel", bus_a.s_sel_o, 4'hf);
        check_eq("t3_rd1_grant", bus_a.grant_o, 1);
        step();
        bus_a.m1_adr_i = 32'h2008;
        mid();
        check_eq("t3_rd2_adr", bus_a.s_adr_o, 32'h2008);
        check_eq("t3_rd2_ack", {bus_a.m1_ack_o, bus_a.m0_ack_o}, 2'b10);
        step();
        bus_a.m1_cyc_i = 0; bus_a.m1_stb_i = 0; bus_a.s_ack_i = 0;
        step();
        mid();
        check_eq("t3_dead_cyc", bus_a.s_cyc_o, 0);
        step();
        mid();
        check_eq("t3_m0_after", bus_a.grant_o, 0);
        check_eq("t3_m0_adr", bus_a.s_adr_o, 32'h3000);

        // Watchdog fires after 8 unacked strobe cycles
        do_reset();
        step();
        bus_a.m0_cyc_i = 1; bus_a.m0_stb_i = 1; bus_a.m0_adr_i = 32'h4000;
        step();
        mid();
        check_eq("t4_stb1_err", bus_a.m0_err_o, 0);
        for (int i = 0; i < 7; i++) begin
            step();
            mid();
            check_eq($sformatf("t4_stb%0d_err", i + 2), bus_a.m0_err_o, 0);
        end
        step();
        mid();
        check_eq("t4_err_pulse", bus_a.m0_err_o, 1);
        check_eq("t4_err_cyc", {bus_a.s_cyc_o, bus_a.s_stb_o}, 0);
        check_eq("t4_err_noack", {bus_a.m0_ack_o, bus_a.m1_err_o}, 0);
        step();
        bus_a.m1_cyc_i = 1; bus_a.m1_stb_i = 1; bus_a.s_ack_i = 1;
        mid();
        check_eq("t4_err_once", bus_a.m0_err_o, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            mid();
            check_eq($sformatf("t4_wrel%0d", i),
                     {bus_a.s_cyc_o, bus_a.m0_ack_o, bus_a.m0_err_o, bus_a.grant_o}, 0);
        end
        step();
        bus_a.m0_cyc_i = 0; bus_a.m0_stb_i = 0; bus_a.s_ack_i = 0;
        step();
        mid();
        check_eq("t4_idle", bus_a.s_cyc_o, 0);
        step();
        mid();
        check_eq("t4_m1_next", {bus_a.grant_o, bus_a.s_cyc_o}, 2'b11);

        // Ack on the deciding edge beats the watchdog
        do_reset();
        step();
        bus_a.m0_cyc_i = 1; bus_a.m0_stb_i = 1;
        step();
        repeat (6) step();
        step();
        bus_a.s_ack_i = 1;
        mid();
        check_eq("t5_late_ack", bus_a.m0_ack_o, 1);
        check_eq("t5_late_noerr", bus_a.m0_err_o, 0);
        step();
        bus_a.s_ack_i = 0; bus_a.m0_cyc_i = 0; bus_a.m0_stb_i = 0;
        mid();
        check_eq("t5_after_noerr", bus_a.m0_err_o, 0);

        // Watchdog disabled: long stall never errs
        step();
        bus_b.m0_cyc_i = 1; bus_b.m0_stb_i = 1;
        n_err = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus_b.m0_err_o) n_err++;
        end
        check_eq("t5_nowd_err", n_err, 0);
        check_eq("t5_nowd_cyc", bus_b.s_cyc_o, 1);
        bus_b.m0_cyc_i = 0; bus_b.m0_stb_i = 0;

        // Reset asserted mid-transfer
        do_reset();
        step();
        bus_a.m0_cyc_i = 1; bus_a.m0_stb_i = 1; bus_a.s_ack_i = 1;
        step();
        mid();
        check_eq("t6_pre_ack", {bus_a.m0_ack_o, bus_a.s_cyc_o}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_cyc", {bus_a.s_cyc_o, bus_a.s_stb_o}, 0);
        check_eq("t6_rst_ack", {bus_a.m0_ack_o, bus_a.m1_ack_o, bus_a.m0_err_o, bus_a.m1_err_o}, 0);
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        bus_a.m0_cyc_i = 1; bus_a.m0_stb_i = 1; bus_a.m1_cyc_i = 1; bus_a.m1_stb_i = 1;
        step();
        mid();
        check_eq("t6_post_m0", {bus_a.grant_o, bus_a.s_cyc_o}, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
